hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
// Pipeline-control bundle between the ID stage and the hazard controller.
//   id_valid        : ID holds a real instruction           (ID side -> ctrl)
//   id_instr[31:0]  : instruction currently in ID           (ID side -> ctrl)
//   ex_branch_taken : BEQ in EX resolved taken this cycle   (EX side -> ctrl)
//   pc_hold         : PC keeps its value                    (ctrl -> front end)
//   ifid_hold       : IF/ID register keeps its value        (ctrl -> front end)
//   ifid_flush      : IF/ID register loads NOP              (ctrl -> front end)
//   idex_bubble     : ID/EX register loads NOP              (ctrl -> front end)
// Modports: master = pipeline side, slave = hazard controller.
// ----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_branch_taken;
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_bubble;

    modport master (
        output id_valid,
        output id_instr,
        output ex_branch_taken,
        input  pc_hold,
        input  ifid_hold,
        input  ifid_flush,
        input  idex_bubble
    );

    modport slave (
        input  id_valid,
        input  id_instr,
        input  ex_branch_taken,
        output pc_hold,
        output ifid_hold,
        output ifid_flush,
        output idex_bubble
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Interlock controller for the ID->EX->MEM->WB pipeline. A three-entry
// scoreboard holds the destination registers still in flight; an ID
// instruction reading one of them stalls the front end. Taken branches and
// jumps flush wrong-path instructions. Saturating stall/flush counters and a
// sticky deadlock flag give visibility into pipeline behaviour.
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   pipe       : pipeline-control bundle (hazard_ctrl_if.slave)
//   stall_cnt  : saturating count of stall cycles
//   flush_cnt  : saturating count of cycles with ifid_flush asserted
//   deadlock   : sticky, set by a 4th consecutive stall cycle
// ----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_ctrl_if.slave     pipe,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             deadlock
);

    // Shared opcode encodings; anything else decodes as an ALU op.
    localparam logic [5:0] OP_SDW  = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LDW  = 6'h23;
    localparam logic [5:0] OP_JUMP = 6'h02;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  consec_r;

    logic [4:0]  sb_ex_r;
    logic [4:0]  sb_mem_r;
    logic [4:0]  sb_wb_r;

    logic [5:0]  opcode_s;
    logic [4:0]  src_a_s;
    logic [4:0]  src_b_s;
    logic [4:0]  dest_s;
    logic        use_a_s;
    logic        use_b_s;
    logic        hazard_s;
    logic        stall_s;
    logic        jump_id_s;
    logic        bubble_s;
    logic        flush_s;

    // A source hazards when it is used, nonzero, and matches an in-flight
    // destination. Since src is nonzero, a match implies a nonzero entry.
    function automatic logic src_pending(
        input logic       used,
        input logic [4:0] src,
        input logic [4:0] e0,
        input logic [4:0] e1,
        input logic [4:0] e2
    );
        return used && (src != 5'd0) &&
               ((src == e0) || (src == e1) || (src == e2));
    endfunction

    // Operand decode: which fields are sources and which is the destination.
    always_comb begin
        opcode_s = pipe.id_instr[31:26];
        src_a_s  = pipe.id_instr[20:16];
        use_a_s  = (opcode_s != OP_JUMP);
        src_b_s  = 5'd0;
        use_b_s  = 1'b0;
        dest_s   = 5'd0;
        case (opcode_s)
            OP_SDW, OP_BEQ: begin
                src_b_s = pipe.id_instr[25:21];
                use_b_s = 1'b1;
                dest_s  = 5'd0;
            end
            OP_LDW: begin
                src_b_s = 5'd0;
                use_b_s = 1'b0;
                dest_s  = pipe.id_instr[25:21];
            end
            OP_JUMP: begin
                src_b_s = 5'd0;
                use_b_s = 1'b0;
                dest_s  = 5'd0;
            end
            default: begin
                src_b_s = pipe.id_instr[15:11];
                use_b_s = 1'b1;
                dest_s  = pipe.id_instr[25:21];
            end
        endcase
    end

    // Hazard detection and pipeline-control outputs. A taken branch kills the
    // ID instruction, so it overrides the stall; flush therefore never
    // coincides with hold.
    always_comb begin
        hazard_s  = pipe.id_valid &&
                    (src_pending(use_a_s, src_a_s, sb_ex_r, sb_mem_r, sb_wb_r) ||
                     src_pending(use_b_s, src_b_s, sb_ex_r, sb_mem_r, sb_wb_r));
        stall_s   = hazard_s && !pipe.ex_branch_taken;
        jump_id_s = pipe.id_valid && (opcode_s == OP_JUMP) && !stall_s;
        bubble_s  = stall_s || pipe.ex_branch_taken;
        flush_s   = pipe.ex_branch_taken || jump_id_s;

        pipe.pc_hold     = stall_s;
        pipe.ifid_hold   = stall_s;
        pipe.idex_bubble = bubble_s;
        pipe.ifid_flush  = flush_s;
    end

    // Scoreboard shift; EX entry takes the new destination unless bubbled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_ex_r  <= 5'd0;
            sb_mem_r <= 5'd0;
            sb_wb_r  <= 5'd0;
        end else begin
            sb_wb_r  <= sb_mem_r;
            sb_mem_r <= sb_ex_r;
            sb_ex_r  <= (bubble_s || !pipe.id_valid) ? 5'd0 : dest_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: STALL tracks whether the front end is currently held.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (stall_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STALL: begin
                if (stall_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Consecutive-stall tracking and sticky deadlock. The first stall cycle
    // is spent in RUN, so consec_r==2 in STALL with stall still asserted is
    // the 4th consecutive stall cycle; legal code never gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consec_r <= 2'd0;
            deadlock <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    consec_r <= 2'd0;
                end
                ST_STALL: begin
                    if (consec_r != 2'd3) begin
                        consec_r <= consec_r + 2'd1;
                    end else begin
                        consec_r <= consec_r;
                    end
                end
                default: begin
                    consec_r <= 2'd0;
                end
            endcase
            if ((state_r == ST_STALL) && stall_s && (consec_r >= 2'd2)) begin
                deadlock <= 1'b1;
            end else begin
                deadlock <= deadlock;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush_s && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
// Table-driven bench for hazard_ctrl with a small expected-result queue:
// each applied vector pushes its expected outputs, and a negedge checker pops
// and compares them. Hand sequences cover counter saturation, deadlock and
// reset asserted in the middle of a stall.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_ALU  = 6'h00;
    localparam logic [5:0] OP_SDW  = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LDW  = 6'h23;
    localparam logic [5:0] OP_JUMP = 6'h02;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             deadlock;

    hazard_ctrl_if hif();

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe      (hif.slave),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .deadlock  (deadlock)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [31:0]      instr;
        logic             br;
        logic             st;   // expected pc_hold and ifid_hold
        logic             fl;   // expected ifid_flush
        logic             bu;   // expected idex_bubble
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
        logic             dl;
    } vec_t;

    vec_t exp_q[$];
    vec_t cur_e;
    vec_t tbl[26];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   vec_id = 0;
    int   sc_m;
    int   fc_m;

    function automatic logic [31:0] alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        return {OP_ALU, d, a, b, 11'h000};
    endfunction

    function automatic logic [31:0] ldw(input logic [4:0] d, input logic [4:0] a, input logic [15:0] imm);
        return {OP_LDW, d, a, imm};
    endfunction

    function automatic logic [31:0] sdw(input logic [4:0] rb, input logic [4:0] ra);
        return {OP_SDW, rb, ra, 16'h0000};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rb, input logic [4:0] ra);
        return {OP_BEQ, rb, ra, 16'h0004};
    endfunction

    // JUMP whose unused source fields all hold r14.
    function automatic logic [31:0] jmp();
        return {OP_JUMP, 5'd14, 5'd14, 16'h7000};
    endfunction

    function automatic vec_t mk(input logic valid, input logic [31:0] instr, input logic br,
                                input logic st, input logic fl, input logic bu,
                                input int sc, input int fc, input logic dl);
        vec_t v;
        v.valid = valid;
        v.instr = instr;
        v.br    = br;
        v.st    = st;
        v.fl    = fl;
        v.bu    = bu;
        v.sc    = sc[CNT_W-1:0];
        v.fc    = fc[CNT_W-1:0];
        v.dl    = dl;
        return v;
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= 15) ? 15 : x + 1;
    endfunction

    // Drive one vector just after the rising edge; the checker compares it
    // at the following falling edge.
    task automatic apply(input vec_t v);
        hif.id_valid        = v.valid;
        hif.id_instr        = v.instr;
        hif.ex_branch_taken = v.br;
        exp_q.push_back(v);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Scoreboard checker: pop the expected record for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur_e = exp_q.pop_front();
            n_vec++;
            if ((hif.pc_hold !== cur_e.st) || (hif.ifid_hold !== cur_e.st) ||
                (hif.ifid_flush !== cur_e.fl) || (hif.idex_bubble !== cur_e.bu) ||
                (stall_cnt !== cur_e.sc) || (flush_cnt !== cur_e.fc) ||
                (deadlock !== cur_e.dl)) begin
                n_miss++;
                $display("FAIL vec%0d: got hold=%b/%b flush=%b bubble=%b sc=%0d fc=%0d dl=%b, want hold=%b flush=%b bubble=%b sc=%0d fc=%0d dl=%b",
                         vec_id, hif.pc_hold, hif.ifid_hold, hif.ifid_flush, hif.idex_bubble,
                         stall_cnt, flush_cnt, deadlock,
                         cur_e.st, cur_e.fl, cur_e.bu, cur_e.sc, cur_e.fc, cur_e.dl);
            end
            vec_id++;
        end
    end

    initial begin
        hif.id_valid        = 1'b0;
        hif.id_instr        = 32'h0000_0000;
        hif.ex_branch_taken = 1'b0;

        //           valid instr                  br    st    fl    bu    sc fc dl
        // back-to-back dependency on r5: 3 stall cycles
        tbl[0]  = mk(1'b0, 32'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        tbl[1]  = mk(1'b1, alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        tbl[2]  = mk(1'b1, alu(5'd6, 5'd5, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0);
        tbl[3]  = mk(1'b1, alu(5'd6, 5'd5, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
        tbl[4]  = mk(1'b1, alu(5'd6, 5'd5, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 1'b0);
        tbl[5]  = mk(1'b1, alu(5'd6, 5'd5, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0);
        // distance-2 dependency on r8 (srcB of ALU is [15:11]): 2 stall cycles
        tbl[6]  = mk(1'b1, alu(5'd8, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0);
        tbl[7]  = mk(1'b1, alu(5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b0);
        tbl[8]  = mk(1'b1, alu(5'd9, 5'd0, 5'd8), 1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 1'b0);
        tbl[9]  = mk(1'b1, alu(5'd9, 5'd0, 5'd8), 1'b0, 1'b1, 1'b0, 1'b1, 4, 0, 1'b0);
        tbl[10] = mk(1'b1, alu(5'd9, 5'd0, 5'd8), 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
        // register 0 never hazards
        tbl[11] = mk(1'b1, alu(5'd0, 5'd3, 5'd4), 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
        tbl[12] = mk(1'b1, alu(5'd10, 5'd0, 5'd0),1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
        // LDW r7 (its [15:11]=r10 is pending but unused), then SDW storing r7
        tbl[13] = mk(1'b1, ldw(5'd7, 5'd0, 16'h5000), 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0);
        tbl[14] = mk(1'b1, sdw(5'd7, 5'd0),       1'b0, 1'b1, 1'b0, 1'b1, 5, 0, 1'b0);
        tbl[15] = mk(1'b1, sdw(5'd7, 5'd0),       1'b0, 1'b1, 1'b0, 1'b1, 6, 0, 1'b0);
        tbl[16] = mk(1'b1, sdw(5'd7, 5'd0),       1'b0, 1'b1, 1'b0, 1'b1, 7, 0, 1'b0);
        tbl[17] = mk(1'b1, sdw(5'd7, 5'd0),       1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0);
        // BEQ writes nothing: reader of its [25:21] does not stall
        tbl[18] = mk(1'b1, beq(5'd12, 5'd0),      1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0);
        tbl[19] = mk(1'b1, alu(5'd13, 5'd12, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 8, 0, 1'b0);
        // taken branch overrides a live hazard on r13
        tbl[20] = mk(1'b1, alu(5'd14, 5'd13, 5'd0), 1'b1, 1'b0, 1'b1, 1'b1, 8, 0, 1'b0);
        tbl[21] = mk(1'b1, alu(5'd14, 5'd0, 5'd0),  1'b0, 1'b0, 1'b0, 1'b0, 8, 1, 1'b0);
        // JUMP with r14 pending in EX: flush only, its fields are not sources
        tbl[22] = mk(1'b1, jmp(),                 1'b0, 1'b0, 1'b1, 1'b0, 8, 1, 1'b0);
        tbl[23] = mk(1'b1, alu(5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 8, 2, 1'b0);
        // taken branch with an empty ID slot
        tbl[24] = mk(1'b0, 32'h0,                 1'b1, 1'b0, 1'b1, 1'b1, 8, 2, 1'b0);
        tbl[25] = mk(1'b0, 32'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 8, 3, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i]);
        end

        // Counter saturation: four 3-cycle stalls and fourteen jumps.
        sc_m = 8;
        fc_m = 3;
        for (int p = 0; p < 4; p++) begin
            apply(mk(1'b1, alu(5'd20, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, sc_m, fc_m, 1'b0));
            for (int k = 0; k < 3; k++) begin
                apply(mk(1'b1, alu(5'd0, 5'd20, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, sc_m, fc_m, 1'b0));
                sc_m = sat_inc(sc_m);
            end
            apply(mk(1'b1, alu(5'd0, 5'd20, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, sc_m, fc_m, 1'b0));
        end
        for (int j = 0; j < 14; j++) begin
            apply(mk(1'b1, jmp(), 1'b0, 1'b0, 1'b1, 1'b0, sc_m, fc_m, 1'b0));
            fc_m = sat_inc(fc_m);
        end
        apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 15, 15, 1'b0));

        // Deadlock: pin r21 in the WB entry so the stall never drains.
        force dut.sb_wb_r = 5'd21;
        for (int c = 0; c < 5; c++) begin
            apply(mk(1'b1, alu(5'd0, 5'd21, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 15, 15, (c == 4)));
        end
        release dut.sb_wb_r;
        for (int c = 0; c < 3; c++) begin
            apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 15, 15, 1'b1));
        end

        // Reset asserted in the middle of a stall on r22.
        apply(mk(1'b1, alu(5'd22, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 15, 15, 1'b1));
        apply(mk(1'b1, alu(5'd0, 5'd22, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 15, 15, 1'b1));
        apply(mk(1'b1, alu(5'd0, 5'd22, 5'd0), 1'b0, 1'b1, 1'b0, 1'b1, 15, 15, 1'b1));
        hif.id_valid        = 1'b1;
        hif.id_instr        = alu(5'd0, 5'd22, 5'd0);
        hif.ex_branch_taken = 1'b0;
        #2;
        check_now("hold_before_rst", {31'd0, hif.pc_hold}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_now("rst_pc_hold",     {31'd0, hif.pc_hold},     32'd0);
        check_now("rst_ifid_hold",   {31'd0, hif.ifid_hold},   32'd0);
        check_now("rst_idex_bubble", {31'd0, hif.idex_bubble}, 32'd0);
        check_now("rst_ifid_flush",  {31'd0, hif.ifid_flush},  32'd0);
        check_now("rst_stall_cnt",   {28'd0, stall_cnt},       32'd0);
        check_now("rst_flush_cnt",   {28'd0, flush_cnt},       32'd0);
        check_now("rst_deadlock",    {31'd0, deadlock},        32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Scoreboard emptied: the same reader no longer stalls.
        apply(mk(1'b1, alu(5'd0, 5'd22, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0));
        apply(mk(1'b1, jmp(),                  1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0));
        apply(mk(1'b0, 32'h0,                  1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
